mips_control_unit: RTL and testbench

MIPS_CONTROL_UNIT -- requirements
Module: mips_control_unit

---
 rtl/mips_pkg.sv | 62 ++++++
 rtl/mips_alu_decoder.sv | 37 +++
 rtl/mips_control_unit.sv | 175 +++++++++++++++++
 tb/tb_mips_control_unit.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: opcode and funct
// codes, FSM state type, ALU control codes and datapath mux encodings.
package mips_pkg;

    // Opcodes (instruction[31:26])
    localparam logic [5:0] OpRtype = 6'b000000;
    localparam logic [5:0] OpLw    = 6'b100011;
    localparam logic [5:0] OpSw    = 6'b101011;
    localparam logic [5:0] OpBeq   = 6'b000100;
    localparam logic [5:0] OpBne   = 6'b000101;
    localparam logic [5:0] OpAddi  = 6'b001000;
    localparam logic [5:0] OpJ     = 6'b000010;

    // R-type funct codes (instruction[5:0])
    localparam logic [5:0] FnAdd = 6'b100000;
    localparam logic [5:0] FnSub = 6'b100010;
    localparam logic [5:0] FnAnd = 6'b100100;
    localparam logic [5:0] FnOr  = 6'b100101;
    localparam logic [5:0] FnSlt = 6'b101010;

    typedef enum logic [3:0] {
        StFetch,
        StDecode,
        StMemAdr,
        StMemRd,
        StMemWb,
        StMemWr,
        StExecute,
        StAluWb,
        StBranch,
        StAddiExec,
        StAddiWb,
        StJump,
        StError
    } state_t;

    typedef enum logic [2:0] {
        AluAnd = 3'b000,
        AluOr  = 3'b001,
        AluAdd = 3'b010,
        AluSub = 3'b110,
        AluSlt = 3'b111
    } alu_control_t;

    typedef enum logic [1:0] {
        AluOpAdd   = 2'b00,
        AluOpSub   = 2'b01,
        AluOpFunct = 2'b10
    } alu_op_t;

    // ALU operand B select
    localparam logic [1:0] SrcBReg    = 2'b00;
    localparam logic [1:0] SrcBFour   = 2'b01;
    localparam logic [1:0] SrcBImm    = 2'b10;
    localparam logic [1:0] SrcBImmSh2 = 2'b11;

    // Next-PC select
    localparam logic [1:0] PcSrcAlu    = 2'b00;
    localparam logic [1:0] PcSrcAluOut = 2'b01;
    localparam logic [1:0] PcSrcJump   = 2'b10;

endpackage

// File: rtl/mips_alu_decoder.sv
// Combinational ALU decoder: ALUOp from the main FSM plus the R-type funct
// field select the ALU operation. funct_valid flags an unknown funct when
// ALUOp requests funct decoding; unknown functs fall back to add.
module mips_alu_decoder
    import mips_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [5:0] funct,
    output logic [2:0] alu_control,
    output logic       funct_valid
);

    // Map ALUOp/funct to an ALU operation code.
    always_comb begin
        alu_control = AluAdd;
        funct_valid = 1'b1;
        unique case (alu_op)
            AluOpAdd: alu_control = AluAdd;
            AluOpSub: alu_control = AluSub;
            AluOpFunct: begin
                case (funct)
                    FnAdd:   alu_control = AluAdd;
                    FnSub:   alu_control = AluSub;
                    FnAnd:   alu_control = AluAnd;
                    FnOr:    alu_control = AluOr;
                    FnSlt:   alu_control = AluSlt;
                    default: begin
                        alu_control = AluAdd;
                        funct_valid = 1'b0;
                    end
                endcase
            end
            default: alu_control = AluAdd;
        endcase
    end

endmodule

// File: rtl/mips_control_unit.sv
// Multicycle MIPS main control unit: Moore FSM driving datapath selects and
// enables for lw, sw, R-type, beq, addi and j. The only Mealy path is the ALU
// zero flag into pc_en during BRANCH.
// Optional feature: define MIPS_BNE_EN to decode bne (opcode 000101) through
// the BRANCH state; otherwise bne is an illegal opcode.
module mips_control_unit
    import mips_pkg::*;
#(
    parameter bit STRICT_DECODE = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       iord,
    output logic       ir_write,
    output logic       mem_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_control,
    output logic       pc_en,
    output logic       illegal_op
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;
    logic       alu_en;
    logic [2:0] dec_control;
    logic       funct_valid;
    logic       pc_write, branch_eq, branch_ne;
    logic       ir_write_raw, mem_write_raw, reg_write_raw, illegal_raw;

    mips_alu_decoder u_alu_decoder (
        .alu_op      (alu_op),
        .funct       (funct),
        .alu_control (dec_control),
        .funct_valid (funct_valid)
    );

    // State register; reset returns to FETCH asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StFetch;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: opcode dispatch in DECODE, funct legality check in EXECUTE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StFetch:  state_d = StDecode;
            StDecode: begin
                case (opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpRtype:    state_d = StExecute;
                    OpBeq:      state_d = StBranch;
`ifdef MIPS_BNE_EN
                    OpBne:      state_d = StBranch;
`endif
                    OpAddi:     state_d = StAddiExec;
                    OpJ:        state_d = StJump;
                    default:    state_d = STRICT_DECODE ? StError : StFetch;
                endcase
            end
            StMemAdr:   state_d = (opcode == OpLw) ? StMemRd : StMemWr;
            StMemRd:    state_d = StMemWb;
            StMemWb:    state_d = StFetch;
            StMemWr:    state_d = StFetch;
            // Unknown funct without strict decode: add executes, write-back skipped.
            StExecute:  state_d = funct_valid ? StAluWb
                                              : (STRICT_DECODE ? StError : StFetch);
            StAluWb:    state_d = StFetch;
            StBranch:   state_d = StFetch;
            StAddiExec: state_d = StAddiWb;
            StAddiWb:   state_d = StFetch;
            StJump:     state_d = StFetch;
            StError:    state_d = StError;
            default:    state_d = StFetch;
        endcase
    end

    // Moore outputs per state; everything not named in a state stays 0.
    always_comb begin
        iord          = 1'b0;
        ir_write_raw  = 1'b0;
        mem_write_raw = 1'b0;
        reg_write_raw = 1'b0;
        reg_dst       = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = SrcBReg;
        pc_src        = PcSrcAlu;
        alu_op        = AluOpAdd;
        alu_en        = 1'b0;
        pc_write      = 1'b0;
        branch_eq     = 1'b0;
        branch_ne     = 1'b0;
        illegal_raw   = 1'b0;
        unique case (state_q)
            StFetch: begin
                ir_write_raw = 1'b1;
                alu_src_b    = SrcBFour;
                alu_en       = 1'b1;
                pc_write     = 1'b1;
            end
            StDecode: begin
                alu_src_b = SrcBImmSh2;
                alu_en    = 1'b1;
            end
            StMemAdr, StAddiExec: begin
                alu_src_a = 1'b1;
                alu_src_b = SrcBImm;
                alu_en    = 1'b1;
            end
            StMemRd: iord = 1'b1;
            StMemWb: begin
                mem_to_reg    = 1'b1;
                reg_write_raw = 1'b1;
            end
            StMemWr: begin
                iord          = 1'b1;
                mem_write_raw = 1'b1;
            end
            StExecute: begin
                alu_src_a = 1'b1;
                alu_op    = AluOpFunct;
                alu_en    = 1'b1;
            end
            StAluWb: begin
                reg_dst       = 1'b1;
                reg_write_raw = 1'b1;
            end
            StBranch: begin
                alu_src_a = 1'b1;
                alu_op    = AluOpSub;
                alu_en    = 1'b1;
                pc_src    = PcSrcAluOut;
`ifdef MIPS_BNE_EN
                // IR is not rewritten in BRANCH, so opcode still names the branch kind.
                if (opcode == OpBne) begin
                    branch_ne = 1'b1;
                end else begin
                    branch_eq = 1'b1;
                end
`else
                branch_eq = 1'b1;
`endif
            end
            StAddiWb: reg_write_raw = 1'b1;
            StJump: begin
                pc_src   = PcSrcJump;
                pc_write = 1'b1;
            end
            StError: illegal_raw = 1'b1;
            default: ;
        endcase
    end

    assign alu_control = alu_en ? dec_control : 3'b000;

    // Write enables are held off combinationally for the whole reset pulse.
    assign ir_write   = ir_write_raw & rst_n;
    assign mem_write  = mem_write_raw & rst_n;
    assign reg_write  = reg_write_raw & rst_n;
    assign illegal_op = illegal_raw & rst_n;
    assign pc_en      = (pc_write | (branch_eq & zero) | (branch_ne & ~zero)) & rst_n;

endmodule

// File: tb/tb_mips_control_unit.sv
// Randomized bench for mips_control_unit. A reference model expands each
// instruction into its expected per-cycle output vectors; two instances
// (STRICT_DECODE 1 and 0) share stimulus and are checked one at a time.
module tb_mips_control_unit;

    localparam logic [5:0] OpLw   = 6'b100011;
    localparam logic [5:0] OpSw   = 6'b101011;
    localparam logic [5:0] OpRt   = 6'b000000;
    localparam logic [5:0] OpBeq  = 6'b000100;
    localparam logic [5:0] OpBne  = 6'b000101;
    localparam logic [5:0] OpAddi = 6'b001000;
    localparam logic [5:0] OpJmp  = 6'b000010;
`ifdef MIPS_BNE_EN
    localparam bit BneEn = 1'b1;
`else
    localparam bit BneEn = 1'b0;
`endif

    localparam logic [3:0] IdFetch = 0, IdDecode = 1, IdMemAdr = 2, IdMemRd = 3, IdMemWb = 4,
                           IdMemWr = 5, IdExec = 6, IdAluWb = 7, IdBranch = 8, IdAddiEx = 9,
                           IdAddiWb = 10, IdJump = 11, IdError = 12;

    typedef struct packed {
        logic [15:0] v;
        logic [1:0]  br;  // 0 none, 1 taken on zero, 2 taken on not-zero
        logic [3:0]  id;
    } step_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] opcode, funct;
    logic       zero;
    logic       sel;
    int         n_total = 0;
    int         n_bad = 0;
    bit         err_pending;
    step_t      exp_q[$];

    logic a_iord, a_irw, a_mw, a_rw, a_rd, a_m2r, a_sa, a_pce, a_ill;
    logic [1:0] a_sb, a_ps;
    logic [2:0] a_alu;
    logic b_iord, b_irw, b_mw, b_rw, b_rd, b_m2r, b_sa, b_pce, b_ill;
    logic [1:0] b_sb, b_ps;
    logic [2:0] b_alu;
    logic [15:0] obs_a, obs_b, obs;

    always #5 clk = ~clk;

    mips_control_unit #(.STRICT_DECODE(1'b1)) u_dut_strict (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .iord(a_iord), .ir_write(a_irw), .mem_write(a_mw), .reg_write(a_rw),
        .reg_dst(a_rd), .mem_to_reg(a_m2r), .alu_src_a(a_sa), .alu_src_b(a_sb),
        .pc_src(a_ps), .alu_control(a_alu), .pc_en(a_pce), .illegal_op(a_ill)
    );

    mips_control_unit #(.STRICT_DECODE(1'b0)) u_dut_lax (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
        .iord(b_iord), .ir_write(b_irw), .mem_write(b_mw), .reg_write(b_rw),
        .reg_dst(b_rd), .mem_to_reg(b_m2r), .alu_src_a(b_sa), .alu_src_b(b_sb),
        .pc_src(b_ps), .alu_control(b_alu), .pc_en(b_pce), .illegal_op(b_ill)
    );

    assign obs_a = {a_iord, a_irw, a_mw, a_rw, a_rd, a_m2r, a_sa, a_sb, a_ps, a_alu, a_pce, a_ill};
    assign obs_b = {b_iord, b_irw, b_mw, b_rw, b_rd, b_m2r, b_sa, b_sb, b_ps, b_alu, b_pce, b_ill};
    assign obs   = sel ? obs_b : obs_a;

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s (dut=%0d t=%0t): got %h expected %h", tag, sel, $time, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input logic iord, irw, mw, rw, rd, m2r, sa,
                                       input logic [1:0] sb, ps, input logic [2:0] alu,
                                       input logic pce, ill);
        return {iord, irw, mw, rw, rd, m2r, sa, sb, ps, alu, pce, ill};
    endfunction

    function automatic string name_of(input logic [3:0] id);
        case (id)
            IdFetch:  return "fetch";
            IdDecode: return "decode";
            IdMemAdr: return "memadr";
            IdMemRd:  return "memrd";
            IdMemWb:  return "memwb";
            IdMemWr:  return "memwr";
            IdExec:   return "execute";
            IdAluWb:  return "aluwb";
            IdBranch: return "branch";
            IdAddiEx: return "addiexec";
            IdAddiWb: return "addiwb";
            IdJump:   return "jump";
            default:  return "error";
        endcase
    endfunction

    // {valid, alu code} for an R-type funct; unknown functs execute as add.
    function automatic logic [3:0] funct_alu(input logic [5:0] fn);
        case (fn)
            6'b100000: return 4'b1_010;
            6'b100010: return 4'b1_110;
            6'b100100: return 4'b1_000;
            6'b100101: return 4'b1_001;
            6'b101010: return 4'b1_111;
            default:   return 4'b0_010;
        endcase
    endfunction

    task automatic push(input logic [3:0] id, input logic [15:0] v, input logic [1:0] br);
        step_t s;
        s.v  = v;
        s.br = br;
        s.id = id;
        exp_q.push_back(s);
    endtask

    // Expand one instruction into its expected cycle-by-cycle outputs.
    task automatic plan(input bit strict, input logic [5:0] op, input logic [5:0] fn);
        logic [3:0] r;
        bit illegal;
        illegal = 1'b0;
        push(IdFetch, mk(0, 1, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 1, 0), 0);
        push(IdDecode, mk(0, 0, 0, 0, 0, 0, 0, 2'b11, 2'b00, 3'b010, 0, 0), 0);
        if (op == OpLw || op == OpSw) begin
            push(IdMemAdr, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), 0);
            if (op == OpLw) begin
                push(IdMemRd, mk(1, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0);
                push(IdMemWb, mk(0, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0);
            end else begin
                push(IdMemWr, mk(1, 0, 1, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0);
            end
        end else if (op == OpRt) begin
            r = funct_alu(fn);
            push(IdExec, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, r[2:0], 0, 0), 0);
            if (r[3]) push(IdAluWb, mk(0, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0);
            else illegal = strict;
        end else if (op == OpBeq || (op == OpBne && BneEn)) begin
            push(IdBranch, mk(0, 0, 0, 0, 0, 0, 1, 2'b00, 2'b01, 3'b110, 0, 0),
                 (op == OpBeq) ? 2'd1 : 2'd2);
        end else if (op == OpAddi) begin
            push(IdAddiEx, mk(0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 3'b010, 0, 0), 0);
            push(IdAddiWb, mk(0, 0, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 0), 0);
        end else if (op == OpJmp) begin
            push(IdJump, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 1, 0), 0);
        end else begin
            illegal = strict;
        end
        if (illegal) begin
            for (int i = 0; i < 10; i++)
                push(IdError, mk(0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 0, 1), 0);
            err_pending = 1'b1;
        end
    endtask

    // Called just after a falling edge; leaves rst_n released before the next rising edge.
    task automatic do_reset();
        logic [15:0] rv;
        rv = mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0);
        rst_n = 1'b0;
        #1;
        check_eq("reset_async", obs, rv);
        @(negedge clk);
        #1;
        check_eq("reset_hold", obs, rv);
        rst_n = 1'b1;
    endtask

    // zmode: 0/1 fixed zero flag, 2 random per cycle. abort_step >= 0 pulses reset there.
    task automatic run_instr(input bit strict, input logic [5:0] op, input logic [5:0] fn,
                             input int zmode, input int abort_step);
        step_t e;
        logic [15:0] exp;
        int step;
        opcode = op;
        funct = fn;
        err_pending = 1'b0;
        plan(strict, op, fn);
        step = 0;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            // ERROR must ignore whatever the instruction register holds.
            if (e.id == IdError) opcode = 6'($urandom);
            zero = (zmode == 2) ? 1'($urandom) : (zmode == 1);
            #1;
            exp = e.v;
            if (e.br == 2'd1) exp[1] = exp[1] | zero;
            if (e.br == 2'd2) exp[1] = exp[1] | ~zero;
            check_eq(name_of(e.id), obs, exp);
            if (step == abort_step) begin
                #2 rst_n = 1'b0;
                #1;
                check_eq("abort_mem_write", {15'd0, obs[13]}, 16'd0);
                check_eq("abort_state", obs,
                         mk(0, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, 3'b010, 0, 0));
                exp_q.delete();
                err_pending = 1'b0;
                @(negedge clk);
                #1 rst_n = 1'b1;
                return;
            end
            step++;
            @(negedge clk);
        end
        if (err_pending) do_reset();
    endtask

    task automatic run_random(input bit strict, input int n);
        logic [5:0] ops[7];
        logic [5:0] fns[5];
        logic [5:0] op, fn;
        int r;
        ops = '{OpLw, OpSw, OpRt, OpBeq, OpAddi, OpJmp, OpRt};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        for (int i = 0; i < n; i++) begin
            r  = $urandom_range(0, 11);
            fn = ($urandom_range(0, 7) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
            if (r < 7)       op = ops[r];
            else if (r < 9)  op = OpBeq;
            else if (r == 9) op = OpBne;
            else if (r == 10) op = 6'($urandom);
            else             op = OpRt;
            run_instr(strict, op, fn, 2, -1);
        end
    endtask

    initial begin
        rst_n  = 1'b0;
        opcode = 6'd0;
        funct  = 6'd0;
        zero   = 1'b0;
        sel    = 1'b0;
        err_pending = 1'b0;
        @(negedge clk);
        do_reset();

        // Strict instance: directed cases first, then random traffic.
        run_instr(1'b1, OpLw, 6'b000000, 2, -1);
        run_instr(1'b1, OpRt, 6'b100010, 2, -1);
        run_instr(1'b1, OpBeq, 6'b000000, 1, -1);
        run_instr(1'b1, OpBeq, 6'b000000, 0, -1);
        run_instr(1'b1, OpBne, 6'b000000, 0, -1);
        run_instr(1'b1, OpSw, 6'b000000, 2, 3);
        run_instr(1'b1, OpAddi, 6'b000000, 2, -1);
        run_instr(1'b1, OpJmp, 6'b000000, 2, -1);
        run_instr(1'b1, 6'b111111, 6'b000000, 2, -1);
        run_instr(1'b1, OpRt, 6'b111111, 2, -1);
        run_random(1'b1, 150);

        // Lax instance: illegal codes fall through instead of trapping.
        sel = 1'b1;
        do_reset();
        run_instr(1'b0, 6'b111111, 6'b000000, 2, -1);
        run_instr(1'b0, OpRt, 6'b000001, 2, -1);
        run_instr(1'b0, OpBne, 6'b000000, 0, -1);
        run_instr(1'b0, OpRt, 6'b101010, 2, -1);
        run_random(1'b0, 80);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
